// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - sequential shift-and-add multiplier, signed/unsigned, start/busy/done handshake
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mag;
    logic               last;

    // Magnitudes fit WIDTH unsigned bits, including the most negative operand.
    always_comb begin
        abs_a  = (signed_mode && a[WIDTH-1]) ? -a : a;
        abs_b  = (signed_mode && b[WIDTH-1]) ? -b : b;
        addend = acc_lo[0] ? mcand : '0;
        sum    = {1'b0, acc_hi} + {1'b0, addend};
        mag    = {sum, acc_lo[WIDTH-1:1]};
        last   = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count   <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        mcand  <= abs_a;
                        acc_lo <= abs_b;
                        acc_hi <= '0;
                        count  <= '0;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                S_RUN: begin
                    // acc_lo holds the unconsumed multiplier bits and the low product bits.
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count + CW'(1);
                    if (last) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= neg ? -mag : mag;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
